// File: rtl/perceptron_feeder.sv
// perceptron_feeder: serial-to-parallel operand loader for the perceptron datapath.
// Accepts (input, coeff) beats one per handshake, assembles N_INPUTS of them into
// two flattened buses and presents them under a valid/ready handshake.
// Optional feature macro: FEEDER_RESULT_CAPTURE_EN (captures the perceptron
// classification at the output handshake).
module perceptron_feeder #(
    parameter int unsigned N_INPUTS = 50,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DATA_W-1:0]                  s_input,
    input  logic [DATA_W-1:0]                  s_coeff,
    input  logic                               s_last,
    input  logic                               abort,
    output logic [N_INPUTS*DATA_W-1:0]         inputs_bus,
    output logic [N_INPUTS*DATA_W-1:0]         coeffs_bus,
    output logic                               out_valid,
    input  logic                               out_ready,
`ifdef FEEDER_RESULT_CAPTURE_EN
    input  logic [2*DATA_W:0]                  classification,
    output logic [2*DATA_W:0]                  result,
    output logic                               result_valid,
`endif
    output logic                               load_error,
    output logic [$clog2(N_INPUTS+1)-1:0]      fill_count
);

    localparam int unsigned CW = $clog2(N_INPUTS + 1);
    localparam logic [CW-1:0] LastIdx = CW'(N_INPUTS - 1);

    typedef enum logic {
        StLoad,
        StFull
    } state_t;

    state_t state;

    // fill_count doubles as the write index: after k accepted beats both equal k.
    logic beat_ok;
    assign beat_ok = s_valid && s_ready && !abort;

    // Single FSM: loads slots in StLoad, holds and hands off the vector in StFull.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StLoad;
            fill_count   <= '0;
            inputs_bus   <= '0;
            coeffs_bus   <= '0;
            out_valid    <= 1'b0;
            load_error   <= 1'b0;
            s_ready      <= 1'b0;
`ifdef FEEDER_RESULT_CAPTURE_EN
            result       <= '0;
            result_valid <= 1'b0;
`endif
        end else begin
            load_error <= 1'b0;
`ifdef FEEDER_RESULT_CAPTURE_EN
            result_valid <= 1'b0;
`endif
            unique case (state)
                StLoad: begin
                    s_ready   <= 1'b1;
                    out_valid <= 1'b0;
                    if (abort) begin
                        // Abort wins over any beat presented in the same cycle.
                        fill_count <= '0;
                    end else if (beat_ok) begin
                        inputs_bus[int'(fill_count)*DATA_W +: DATA_W] <= s_input;
                        coeffs_bus[int'(fill_count)*DATA_W +: DATA_W] <= s_coeff;
                        if (fill_count == LastIdx) begin
                            // Vector complete by count; a missing s_last is flagged only.
                            state      <= StFull;
                            s_ready    <= 1'b0;
                            out_valid  <= 1'b1;
                            fill_count <= fill_count + CW'(1);
                            load_error <= !s_last;
                        end else if (s_last) begin
                            // Early last: drop the partial vector, stale slots remain.
                            fill_count <= '0;
                            load_error <= 1'b1;
                        end else begin
                            fill_count <= fill_count + CW'(1);
                        end
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        state      <= StLoad;
                        out_valid  <= 1'b0;
                        fill_count <= '0;
                        s_ready    <= 1'b1;
`ifdef FEEDER_RESULT_CAPTURE_EN
                        result       <= classification;
                        result_valid <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= StLoad;
                end
            endcase
        end
    end

endmodule

// File: doc/perceptron_feeder.md
Name: perceptron_feeder

Overview:
Serial-to-parallel loader that builds one perceptron operand set from a stream of (input, coefficient) pairs. It accepts pairs one per handshake and assembles N_INPUTS of them into two flattened parallel buses. It then holds both buses stable under a valid/ready handshake toward the combinational perceptron datapath and its downstream consumer. It is the write-side counterpart that drives the perceptron's 50 input and 50 coefficient operands.

Parameters:
N_INPUTS, 50, number of (input, coeff) pairs per vector
DATA_W, 16, signed width of each input and coefficient

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
s_valid  in  1  stream beat valid
s_ready  out  1  loader can accept a beat
s_input  in  DATA_W  signed input sample of the beat
s_coeff  in  DATA_W  signed coefficient of the beat
s_last  in  1  marks the final beat of a vector
abort  in  1  synchronous discard of the partial vector
inputs_bus  out  N_INPUTS*DATA_W  slot k at bits [k*DATA_W +: DATA_W]
coeffs_bus  out  N_INPUTS*DATA_W  same packing as inputs_bus
out_valid  out  1  complete vector presented
out_ready  in  1  consumer accepts the presented vector
load_error  out  1  one-cycle pulse on a framing error
fill_count  out  $clog2(N_INPUTS+1)  slots written in the current vector

Behaviour:
- Reset (async, rst=1): state=LOAD, idx=0, fill_count=0, inputs_bus=0, coeffs_bus=0, out_valid=0, load_error=0, s_ready=0.
- s_ready is registered. It rises on the first clk edge after rst deasserts.
- States are LOAD and FULL.
- LOAD: s_ready=1, out_valid=0. An accepted beat (s_valid & s_ready) writes s_input/s_coeff into slot idx; idx increments and fill_count=idx+1.
- Accepted beat with idx==N_INPUTS-1: the vector is complete regardless of s_last. Next cycle: state=FULL, s_ready=0, out_valid=1.
- If that final beat has s_last=0, load_error pulses 1 cycle and the vector is still presented.
- Accepted beat with s_last=1 and idx<N_INPUTS-1 (early last): the beat is written, load_error pulses 1 cycle, idx and fill_count go to 0, state stays LOAD and the vector is not presented. Stale slot contents remain on the buses.
- FULL: buses are stable and s_ready=0. When out_valid & out_ready: next cycle out_valid=0, state=LOAD, idx=0, fill_count=0, s_ready=1.
- The buses keep their contents after the handshake; slots are overwritten only by new beats.
- Latency: last beat accepted at edge T gives out_valid=1 after T. Minimum vector period is N_INPUTS+1 cycles. No beat is accepted in the cycle of the output handshake.
- abort=1 in LOAD: idx and fill_count go to 0 and any beat in the same cycle is dropped (abort has priority). abort=1 in FULL is ignored.
- Register updates are synchronous; only reset is asynchronous. Reset mid-vector discards all state.
- The block performs no arithmetic; data is passed bit-exact and signed interpretation is the consumer's.

Optional Feature:
Macro FEEDER_RESULT_CAPTURE_EN.
- Defined: adds ports classification (in, 2*DATA_W+1, from the perceptron), result (out, 2*DATA_W+1) and result_valid (out, 1).
- At the out_valid & out_ready edge, classification is registered into result and result_valid pulses high for exactly one cycle. result holds until the next capture; result and result_valid reset to 0.
- Not defined: these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Load 50 beats (input=k, coeff=-k, s_last on k=49) with out_ready=0 -> out_valid=1 after beat 49; slot 7 reads 0x0007/0xFFF9; s_ready=0; buses stable for 20 cycles; fill_count=50.
- Set out_ready=1 in FULL -> out_valid=0 and s_ready=1 next cycle, fill_count=0; next vector of 50 beats of 0x1234 overwrites all slots.
- s_last on beat 10 -> load_error 1-cycle pulse, fill_count=0, no out_valid; the next 50 beats form a valid vector.
- 50 beats with s_last never set -> vector presented and load_error pulses on the cycle after beat 49.
- abort together with s_valid at beat 20 -> beat dropped, fill_count=0; rst asserted at beat 30 -> buses=0, out_valid=0 immediately; s_ready=1 one edge after release.
- With FEEDER_RESULT_CAPTURE_EN, classification=33'h0_0000_0A00 at handshake -> result=0xA00 with a one-cycle result_valid pulse; without it, a build with the ports unconnected passes.
